// File: rtl/multi_dataflow_engine_ctrl.sv
// rtl/multi_dataflow_engine_ctrl.sv - engine-side start/beat-count/done responder for the HWPE control FSM
module multi_dataflow_engine_ctrl #(
  parameter int CNT_LEN = 1024,
  parameter int CNT_W   = $clog2(CNT_LEN) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cnt_limit_i,
  input  logic             out_valid_i,
  input  logic             out_ready_i,
  output logic             ap_start_o,
  input  logic             ap_ready_i,
  input  logic             ap_done_i,
  input  logic             ap_idle_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o,
  output logic             ready_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] limit_q;
  logic             ap_start_q;
  logic             done_q;
  logic             kdone_seen_q;
  logic             cnt_hit_q;

  logic [CNT_W-1:0] cnt_inc;
  logic             beat;
  logic             last_beat;
  logic             kdone_now;
  logic             unused_idle;

  // Kernel idle is status only; it never steers sequencing.
  assign unused_idle = ap_idle_i;

  // Per-cycle RUN events: a counted beat, the beat that reaches the limit, kernel done seen so far.
  always_comb begin
    cnt_inc   = cnt_q + CNT_W'(1);
    beat      = out_valid_i & out_ready_i & ~cnt_hit_q;
    last_beat = beat & (cnt_inc == limit_q);
    kdone_now = kdone_seen_q | ap_done_i;
  end

  // Job FSM with registered outputs; clear beats enable, enable beats normal operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      limit_q      <= '0;
      ap_start_q   <= 1'b0;
      done_q       <= 1'b0;
      kdone_seen_q <= 1'b0;
      cnt_hit_q    <= 1'b0;
    end else if (clear_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ap_start_q   <= 1'b0;
      done_q       <= 1'b0;
      kdone_seen_q <= 1'b0;
      cnt_hit_q    <= 1'b0;
    end else if (enable_i) begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            limit_q      <= cnt_limit_i;
            cnt_q        <= '0;
            kdone_seen_q <= 1'b0;
            cnt_hit_q    <= 1'b0;
            if (cnt_limit_i == '0) begin
              // Empty job: no kernel start, report completion straight away.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_RUN;
              ap_start_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (ap_ready_i) ap_start_q <= 1'b0;
          if (beat) cnt_q <= cnt_inc;
          if (last_beat) cnt_hit_q <= 1'b1;
          if (ap_done_i) kdone_seen_q <= 1'b1;
          if ((cnt_hit_q | last_beat) & kdone_now) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            // The job is over, so a start the kernel never acknowledged must not linger.
            ap_start_q <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          done_q       <= 1'b0;
          kdone_seen_q <= 1'b0;
          cnt_hit_q    <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          done_q     <= 1'b0;
          ap_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign ap_start_o = ap_start_q;
  assign cnt_o      = cnt_q;
  assign done_o     = done_q;
  assign ready_o    = (state_q == ST_IDLE);

endmodule

// File: tb/tb_multi_dataflow_engine_ctrl.sv
// tb/tb_multi_dataflow_engine_ctrl.sv - scoreboard bench for multi_dataflow_engine_ctrl
module tb_multi_dataflow_engine_ctrl;
  localparam int CNT_LEN = 1024;
  localparam int CNT_W   = 11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear_i;
  logic             enable_i;
  logic             start_i;
  logic [CNT_W-1:0] cnt_limit_i;
  logic             out_valid_i;
  logic             out_ready_i;
  logic             ap_start_o;
  logic             ap_ready_i;
  logic             ap_done_i;
  logic             ap_idle_i;
  logic [CNT_W-1:0] cnt_o;
  logic             done_o;
  logic             ready_o;

  always #5 clk = ~clk;

  multi_dataflow_engine_ctrl #(.CNT_LEN(CNT_LEN), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear_i),
    .enable_i    (enable_i),
    .start_i     (start_i),
    .cnt_limit_i (cnt_limit_i),
    .out_valid_i (out_valid_i),
    .out_ready_i (out_ready_i),
    .ap_start_o  (ap_start_o),
    .ap_ready_i  (ap_ready_i),
    .ap_done_i   (ap_done_i),
    .ap_idle_i   (ap_idle_i),
    .cnt_o       (cnt_o),
    .done_o      (done_o),
    .ready_o     (ready_o)
  );

  typedef struct {
    int cnt;
    int done_cyc;
    int st_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   st_cnt = 0;
  bit   chk_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Monitor: counts ap_start cycles, pops the expected job record whenever done_o shows.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (ap_start_o) st_cnt++;
      if (chk_ready) begin
        check("ready_after_done", ready_o, 1);
        chk_ready = 0;
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", done_o, 0);
        end else begin
          e = exp_q.pop_front();
          check("job_cnt", cnt_o, e.cnt);
          check("done_cycle", cyc, e.done_cyc);
          check("ap_start_cycles", st_cnt, e.st_cycles);
          check("ready_during_done", ready_o, 0);
          st_cnt    = 0;
          chk_ready = 1;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
        check("done_missing", done_o, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_i     = 1'b0;
    enable_i    = 1'b1;
    start_i     = 1'b0;
    out_valid_i = 1'b0;
    out_ready_i = 1'b0;
    ap_ready_i  = 1'b0;
    ap_done_i   = 1'b0;
    ap_idle_i   = 1'b0;
  endtask

  // One job driven against a job-level model: beats count up to the limit, the job ends in the
  // first cycle where the limit is reached and a kernel done has been seen; done_o follows a cycle later.
  // rel=0: ap_done at job cycle dval; rel=1: ap_done dval cycles after the limit-reaching beat.
  task automatic run_job(input int limit, input int rdy_at, input bit rel, input int dval,
                         input int beat_from, input int pct);
    int   c0, counted, hit_k, tgt, n;
    bit   ks, fin, v, r, dn;
    exp_t e;
    c0          = cyc;
    st_cnt      = 0;
    idle_inputs();
    start_i     = 1'b1;
    cnt_limit_i = CNT_W'(limit);
    out_valid_i = 1'($urandom_range(0, 1));
    out_ready_i = 1'($urandom_range(0, 1));
    if (limit == 0) begin
      e.cnt = 0; e.done_cyc = c0 + 1; e.st_cycles = 0;
      exp_q.push_back(e);
      step();
    end else begin
      counted = 0; hit_k = -1; ks = 0; fin = 0;
      tgt = rel ? -1 : ((dval > rdy_at) ? dval : rdy_at);
      step();
      for (int k = 1; k < 5000 && !fin; k++) begin
        start_i     = 1'($urandom_range(0, 1));
        cnt_limit_i = CNT_W'($urandom);
        v = ($urandom_range(0, 99) < pct);
        r = ($urandom_range(0, 99) < pct) && (k >= beat_from);
        if (k > 2 * limit + 30) begin v = 1; r = 1; end
        if (counted < limit && v && r) begin
          counted++;
          if (counted == limit) hit_k = k;
        end
        if (rel && hit_k >= 0 && tgt < 0) tgt = (hit_k + dval > rdy_at) ? hit_k + dval : rdy_at;
        dn = (k == tgt);
        if (dn) ks = 1;
        out_valid_i = v;
        out_ready_i = r;
        ap_ready_i  = (k == rdy_at);
        ap_done_i   = dn;
        if (counted == limit && ks) begin
          fin = 1;
          e.cnt = limit; e.done_cyc = c0 + k + 1; e.st_cycles = rdy_at;
          exp_q.push_back(e);
        end
        step();
      end
    end
    // DONE cycle: beats here and in IDLE must not move the counter.
    idle_inputs();
    out_valid_i = 1'b1;
    out_ready_i = 1'b1;
    step();
    n = $urandom_range(1, 3);
    repeat (n) begin
      out_valid_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("cnt_hold_idle", cnt_o, limit);
      step();
    end
    idle_inputs();
  endtask

  task automatic freeze_clear();
    idle_inputs();
    start_i = 1'b1; cnt_limit_i = CNT_W'(8);
    step();
    start_i = 1'b0; out_valid_i = 1'b1; out_ready_i = 1'b1;
    step();
    enable_i = 1'b0; ap_ready_i = 1'b1; ap_done_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("freeze_cnt", cnt_o, 1);
      check("freeze_ap_start", ap_start_o, 1);
      step();
    end
    enable_i = 1'b1; ap_done_i = 1'b0; ap_ready_i = 1'b1;
    step();
    ap_ready_i = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("pre_clear_cnt", cnt_o, 5);
    check("pre_clear_ap_start", ap_start_o, 0);
    check("pre_clear_ready", ready_o, 0);
    clear_i = 1'b1;
    step();
    idle_inputs();
    @(negedge clk);
    check("clear_cnt", cnt_o, 0);
    check("clear_ap_start", ap_start_o, 0);
    check("clear_ready", ready_o, 1);
    check("clear_done", done_o, 0);
    step();
  endtask

  task automatic reset_mid_run();
    idle_inputs();
    start_i = 1'b1; cnt_limit_i = CNT_W'(5);
    step();
    start_i = 1'b0; out_valid_i = 1'b1; out_ready_i = 1'b1;
    step();
    step();
    check("pre_reset_cnt", cnt_o, 2);
    check("pre_reset_ap_start", ap_start_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ap_start", ap_start_o, 0);
    check("async_reset_cnt", cnt_o, 0);
    check("async_reset_done", done_o, 0);
    check("async_reset_ready", ready_o, 1);
    idle_inputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int limit, rdy_at, dval, pct;
    bit rel;
    rst_n = 1'b0;
    cnt_limit_i = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", ready_o, 1);
    check("reset_done", done_o, 0);
    check("reset_ap_start", ap_start_o, 0);
    check("reset_cnt", cnt_o, 0);
    step();

    run_job(4, 2, 1'b1, 3, 1, 50);
    run_job(3, 1, 1'b0, 1, 2, 60);
    run_job(2, 1, 1'b1, 0, 1, 100);
    run_job(0, 1, 1'b0, 1, 1, 50);
    freeze_clear();
    reset_mid_run();
    for (int j = 0; j < 30; j++) begin
      limit  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      rdy_at = $urandom_range(1, 3);
      rel    = 1'($urandom_range(0, 1));
      dval   = rel ? $urandom_range(0, 3) : $urandom_range(1, limit + 4);
      pct    = $urandom_range(50, 90);
      run_job(limit, rdy_at, rel, dval, 1, pct);
    end
    run_job(CNT_LEN, 1, 1'b1, 0, 1, 95);

    repeat (5) step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
